// File: rtl/cam_dual_window_capture.sv
// cam_dual_window_capture
// Camera pixel-stream front end: captures a display window and a calculation
// window of every complete frame into two RAM write ports, with an optional
// column-marker overlay, plus end-of-window and end-of-frame strobes.
module cam_dual_window_capture #(
    parameter int unsigned DW          = 3,
    parameter int unsigned XW          = 10,
    parameter int unsigned YW          = 9,
    parameter int unsigned CLK_PER_PIX = 2,
    parameter int unsigned DISP_X0     = 270,
    parameter int unsigned DISP_Y0     = 190,
    parameter int unsigned DISP_W      = 100,
    parameter int unsigned DISP_H      = 100,
    parameter int unsigned DISP_AW     = 16,
    parameter int unsigned CALC_X0     = 318,
    parameter int unsigned CALC_Y0     = 238,
    parameter int unsigned CALC_W      = 79,
    parameter int unsigned CALC_H      = 16,
    parameter int unsigned CALC_AW     = 11,
    parameter int unsigned MARK_X0     = 328,
    parameter int unsigned MARK_W      = 2
) (
    input  logic               pclk,
    input  logic               rst,
    input  logic               vsync,
    input  logic               href,
    input  logic [DW-1:0]      d,
    input  logic               ovl_en,
    input  logic               calc_src,
    output logic [DW-1:0]      disp_data,
    output logic [DISP_AW-1:0] disp_addr,
    output logic               disp_we,
    output logic [DW-1:0]      calc_data,
    output logic [CALC_AW-1:0] calc_addr,
    output logic               calc_we,
    output logic               calc_done,
    output logic               frame_done
);

    // Phase counter width; a 1-cycle pixel still keeps a 1-bit (constant 0) phase.
    localparam int unsigned PW  = (CLK_PER_PIX > 1) ? $clog2(CLK_PER_PIX) : 1;
    // One extra bit on coordinate compares so window end bounds never overflow.
    localparam int unsigned XCW = XW + 1;
    localparam int unsigned YCW = YW + 1;

    localparam logic [PW-1:0]      PHASE_LAST = PW'(CLK_PER_PIX - 1);

    localparam logic [XCW-1:0]     DISP_X_LO  = XCW'(DISP_X0);
    localparam logic [XCW-1:0]     DISP_X_HI  = XCW'(DISP_X0 + DISP_W);
    localparam logic [YCW-1:0]     DISP_Y_LO  = YCW'(DISP_Y0);
    localparam logic [YCW-1:0]     DISP_Y_HI  = YCW'(DISP_Y0 + DISP_H);

    localparam logic [XCW-1:0]     CALC_X_LO  = XCW'(CALC_X0);
    localparam logic [XCW-1:0]     CALC_X_HI  = XCW'(CALC_X0 + CALC_W);
    localparam logic [YCW-1:0]     CALC_Y_LO  = YCW'(CALC_Y0);
    localparam logic [YCW-1:0]     CALC_Y_HI  = YCW'(CALC_Y0 + CALC_H);

    localparam logic [XCW-1:0]     MARK_X_LO  = XCW'(MARK_X0);
    localparam logic [XCW-1:0]     MARK_X_HI  = XCW'(MARK_X0 + MARK_W);

    localparam logic [CALC_AW-1:0] CALC_LAST  = CALC_AW'(CALC_W * CALC_H - 1);

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        SYNC      = 2'd1,
        ACTIVE    = 2'd2
    } state_t;

    state_t               state;
    logic                 href_q;
    logic [PW-1:0]        phase;
    logic [XW-1:0]        x;
    logic [YW-1:0]        y;
    logic [DISP_AW-1:0]   disp_ptr;
    logic [CALC_AW-1:0]   calc_ptr;

    logic                 strobe;
    logic                 href_fall;
    logic                 in_disp;
    logic                 in_calc;
    logic                 in_mark;
    logic [XCW-1:0]       x_ext;
    logic [YCW-1:0]       y_ext;
    logic [XW-1:0]        x_next;
    logic [YW-1:0]        y_next;
    logic [DW-1:0]        mark_pix;
    logic [DW-1:0]        disp_pix;
    logic [DW-1:0]        calc_pix;

    // Pixel strobe, window/marker decode and per-port write data selection.
    always_comb begin
        strobe    = 1'b0;
        href_fall = 1'b0;
        x_ext     = {1'b0, x};
        y_ext     = {1'b0, y};
        in_disp   = 1'b0;
        in_calc   = 1'b0;
        in_mark   = 1'b0;
        x_next    = x;
        y_next    = y;
        mark_pix  = '0;
        disp_pix  = d;
        calc_pix  = d;

        strobe    = (state == ACTIVE) && href && (phase == PHASE_LAST);
        href_fall = href_q && !href;

        in_disp   = (x_ext >= DISP_X_LO) && (x_ext < DISP_X_HI) &&
                    (y_ext >= DISP_Y_LO) && (y_ext < DISP_Y_HI);
        in_calc   = (x_ext >= CALC_X_LO) && (x_ext < CALC_X_HI) &&
                    (y_ext >= CALC_Y_LO) && (y_ext < CALC_Y_HI);
        in_mark   = (x_ext >= MARK_X_LO) && (x_ext < MARK_X_HI);

        // Coordinates saturate at all-ones instead of wrapping.
        x_next    = (&x) ? x : x + XW'(1);
        y_next    = (&y) ? y : y + YW'(1);

        mark_pix  = {DW{in_mark}};
        disp_pix  = (ovl_en && in_calc) ? mark_pix : d;
        calc_pix  = calc_src ? d : mark_pix;
    end

    // Frame state machine: only frames that start with a full vsync pulse are captured.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state <= WAIT_SYNC;
        end else begin
            case (state)
                WAIT_SYNC: if (vsync)  state <= SYNC;
                SYNC:      if (!vsync) state <= ACTIVE;
                ACTIVE:    if (vsync)  state <= SYNC;
                default:               state <= WAIT_SYNC;
            endcase
        end
    end

    // Pixel phase within href and delayed href for falling-edge detection.
    always_ff @(posedge pclk) begin
        if (rst) begin
            href_q <= 1'b0;
            phase  <= '0;
        end else begin
            href_q <= href;
            if (state == SYNC || !href) begin
                phase <= '0;
            end else if (phase == PHASE_LAST) begin
                phase <= '0;
            end else begin
                phase <= phase + PW'(1);
            end
        end
    end

    // Column/line position; a line only counts if it delivered at least one pixel.
    always_ff @(posedge pclk) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (state == SYNC) begin
            x <= '0;
            y <= '0;
        end else if (state == ACTIVE) begin
            if (strobe) begin
                x <= x_next;
            end else if (href_fall) begin
                if (x != '0) begin
                    y <= y_next;
                end
                x <= '0;
            end
        end
    end

    // Running write addresses, restarted once per frame.
    always_ff @(posedge pclk) begin
        if (rst) begin
            disp_ptr <= '0;
            calc_ptr <= '0;
        end else if (state == SYNC) begin
            disp_ptr <= '0;
            calc_ptr <= '0;
        end else if (strobe) begin
            if (in_disp) begin
                disp_ptr <= disp_ptr + DISP_AW'(1);
            end
            if (in_calc) begin
                calc_ptr <= calc_ptr + CALC_AW'(1);
            end
        end
    end

    // Display RAM write port; address and data hold between writes.
    always_ff @(posedge pclk) begin
        if (rst) begin
            disp_we   <= 1'b0;
            disp_addr <= '0;
            disp_data <= '0;
        end else begin
            disp_we <= 1'b0;
            if (strobe && in_disp) begin
                disp_we   <= 1'b1;
                disp_addr <= disp_ptr;
                disp_data <= disp_pix;
            end
        end
    end

    // Calc RAM write port and end-of-window strobe on the last window address.
    always_ff @(posedge pclk) begin
        if (rst) begin
            calc_we   <= 1'b0;
            calc_addr <= '0;
            calc_data <= '0;
            calc_done <= 1'b0;
        end else begin
            calc_we   <= 1'b0;
            calc_done <= 1'b0;
            if (strobe && in_calc) begin
                calc_we   <= 1'b1;
                calc_addr <= calc_ptr;
                calc_data <= calc_pix;
                calc_done <= (calc_ptr == CALC_LAST);
            end
        end
    end

    // End-of-frame strobe on the first vsync sample after an active frame.
    always_ff @(posedge pclk) begin
        if (rst) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= (state == ACTIVE) && vsync;
        end
    end

endmodule

// File: tb/tb_cam_dual_window_capture.sv
// Bench for cam_dual_window_capture: small windows on a 20x10 frame, random
// pixel data and line lengths, compared against a per-pixel window model.
module tb_cam_dual_window_capture;

    localparam int DW      = 3;
    localparam int CPP     = 2;
    localparam int DX0     = 4;
    localparam int DY0     = 2;
    localparam int DWD     = 10;
    localparam int DHT     = 6;
    localparam int DAW     = 7;
    localparam int CX0     = 7;
    localparam int CY0     = 4;
    localparam int CWD     = 5;
    localparam int CHT     = 3;
    localparam int CAW     = 4;
    localparam int MX0     = 9;
    localparam int MWD     = 2;
    localparam int FRAME_W = 20;
    localparam int FRAME_H = 10;
    localparam int DTOT    = DWD * DHT;
    localparam int CTOT    = CWD * CHT;

    logic               pclk;
    logic               rst;
    logic               vsync;
    logic               href;
    logic [DW-1:0]      d;
    logic               ovl_en;
    logic               calc_src;
    logic [DW-1:0]      disp_data;
    logic [DAW-1:0]     disp_addr;
    logic               disp_we;
    logic [DW-1:0]      calc_data;
    logic [CAW-1:0]     calc_addr;
    logic               calc_we;
    logic               calc_done;
    logic               frame_done;

    int checks   = 0;
    int failures = 0;

    logic [DAW+DW-1:0] obs_disp[$];
    logic [DAW+DW-1:0] exp_disp[$];
    logic [CAW+DW-1:0] obs_calc[$];
    logic [CAW+DW-1:0] exp_calc[$];
    logic [CAW:0]      obs_cdone[$];
    int                fd_cnt = 0;
    int                mrow;
    bit                model_on;

    cam_dual_window_capture #(
        .DW(DW), .XW(10), .YW(9), .CLK_PER_PIX(CPP),
        .DISP_X0(DX0), .DISP_Y0(DY0), .DISP_W(DWD), .DISP_H(DHT), .DISP_AW(DAW),
        .CALC_X0(CX0), .CALC_Y0(CY0), .CALC_W(CWD), .CALC_H(CHT), .CALC_AW(CAW),
        .MARK_X0(MX0), .MARK_W(MWD)
    ) dut (
        .pclk(pclk), .rst(rst), .vsync(vsync), .href(href), .d(d),
        .ovl_en(ovl_en), .calc_src(calc_src),
        .disp_data(disp_data), .disp_addr(disp_addr), .disp_we(disp_we),
        .calc_data(calc_data), .calc_addr(calc_addr), .calc_we(calc_we),
        .calc_done(calc_done), .frame_done(frame_done)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Record every write and strobe, sampled on the falling edge.
    always @(negedge pclk) begin
        if (disp_we)    obs_disp.push_back({disp_addr, disp_data});
        if (calc_we)    obs_calc.push_back({calc_addr, calc_data});
        if (calc_done)  obs_cdone.push_back({calc_we, calc_addr});
        if (frame_done) fd_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    // Reference: what one completed pixel at (c, r) must produce on each RAM.
    function automatic void model_pixel(input int c, input int r, input logic [DW-1:0] dv,
                                        input logic ov, input logic src);
        bit             in_d;
        bit             in_c;
        logic [DW-1:0]  mark;
        in_d = (c >= DX0) && (c < DX0 + DWD) && (r >= DY0) && (r < DY0 + DHT);
        in_c = (c >= CX0) && (c < CX0 + CWD) && (r >= CY0) && (r < CY0 + CHT);
        mark = ((c >= MX0) && (c < MX0 + MWD)) ? 3'b111 : 3'b000;
        if (in_d) exp_disp.push_back({DAW'(exp_disp.size()), (ov && in_c) ? mark : dv});
        if (in_c) exp_calc.push_back({CAW'(exp_calc.size()), src ? dv : mark});
    endfunction

    // One href line of len pclks; a trailing partial pixel is never completed.
    task automatic drive_line(input int len, input int mode);
        for (int k = 0; k < len; k++) begin
            href = 1'b1;
            if (mode == 1) begin
                d        = 3'b101;
                ovl_en   = 1'b1;
                calc_src = 1'b0;
            end else begin
                d        = DW'($urandom);
                ovl_en   = 1'($urandom);
                calc_src = 1'($urandom);
            end
            if (model_on && (k % CPP == CPP - 1)) model_pixel(k / CPP, mrow, d, ovl_en, calc_src);
            step(1);
        end
        href = 1'b0;
        d    = DW'($urandom);
        if (model_on && (len / CPP > 0)) mrow++;
        step(3);
    endtask

    // pattern: 0 full lines, 1 random short lines, 2 odd-length and 1-pclk lines.
    task automatic run_frame(input string tag, input int mode, input int pattern,
                             input int rst_line, input bit full);
        int db, cb, kb, fb, len, n7, n0, n5;
        db = obs_disp.size();
        cb = obs_calc.size();
        kb = obs_cdone.size();
        fb = fd_cnt;
        exp_disp.delete();
        exp_calc.delete();
        mrow     = 0;
        model_on = 1'b1;
        vsync    = 1'b0;
        step(2);
        for (int line = 0; line < FRAME_H; line++) begin
            if (line == rst_line) begin
                rst = 1'b1;
                step(2);
                chk($sformatf("%s reset_outputs", tag),
                    {disp_we, calc_we, calc_done, frame_done, disp_addr, calc_addr,
                     disp_data, calc_data}, 64'd0);
                rst      = 1'b0;
                model_on = 1'b0;
                step(1);
            end
            len = FRAME_W * CPP;
            if (pattern == 1 && $urandom_range(0, 2) == 0) len = $urandom_range(0, FRAME_W * CPP);
            if (pattern == 2 && line == 1) len = 2 * CPP + 1;
            if (pattern == 2 && line == 2) len = 1;
            drive_line(len, mode);
        end
        vsync = 1'b1;
        step(4);

        chk($sformatf("%s disp_count", tag), obs_disp.size() - db, exp_disp.size());
        foreach (exp_disp[i])
            if (db + i < obs_disp.size())
                chk($sformatf("%s disp_write[%0d]", tag, i), obs_disp[db + i], exp_disp[i]);
        chk($sformatf("%s calc_count", tag), obs_calc.size() - cb, exp_calc.size());
        foreach (exp_calc[i])
            if (cb + i < obs_calc.size())
                chk($sformatf("%s calc_write[%0d]", tag, i), obs_calc[cb + i], exp_calc[i]);
        if (full) begin
            chk($sformatf("%s disp_full", tag), obs_disp.size() - db, DTOT);
            chk($sformatf("%s calc_full", tag), obs_calc.size() - cb, CTOT);
        end
        chk($sformatf("%s frame_done_count", tag), fd_cnt - fb, model_on ? 1 : 0);
        chk($sformatf("%s calc_done_count", tag), obs_cdone.size() - kb,
            (exp_calc.size() == CTOT) ? 1 : 0);
        for (int j = kb; j < obs_cdone.size(); j++)
            chk($sformatf("%s calc_done_write", tag), obs_cdone[j], {1'b1, CAW'(CTOT - 1)});

        if (mode == 1) begin
            n7 = 0; n0 = 0; n5 = 0;
            for (int i = db; i < obs_disp.size(); i++) begin
                if (obs_disp[i][DW-1:0] == 3'd7) n7++;
                if (obs_disp[i][DW-1:0] == 3'd0) n0++;
                if (obs_disp[i][DW-1:0] == 3'd5) n5++;
            end
            chk($sformatf("%s overlay_marker", tag), n7, MWD * CHT);
            chk($sformatf("%s overlay_zero", tag), n0, CTOT - MWD * CHT);
            chk($sformatf("%s overlay_live", tag), n5, DTOT - CTOT);
        end
    endtask

    initial begin
        rst      = 1'b1;
        vsync    = 1'b0;
        href     = 1'b0;
        d        = '0;
        ovl_en   = 1'b0;
        calc_src = 1'b0;
        step(3);
        chk("reset_outputs",
            {disp_we, calc_we, calc_done, frame_done, disp_addr, calc_addr, disp_data, calc_data},
            64'd0);
        rst = 1'b0;
        step(2);
        vsync = 1'b1;
        step(4);

        run_frame("random_full",   0, 0, -1, 1'b1);
        run_frame("overlay",       1, 0, -1, 1'b1);
        run_frame("odd_lines",     0, 2, -1, 1'b1);
        run_frame("short_lines",   0, 1, -1, 1'b0);
        run_frame("mid_reset",     0, 0,  5, 1'b0);
        run_frame("after_reset",   0, 0, -1, 1'b1);
        run_frame("back_to_back",  0, 0, -1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
